i2c_txn_sequencer: RTL and testbench

- Multi-requester I2C master transaction scheduler.
- Round-robin arbitrates NUM_REQ clients for one shared byte-level I2C master engine.
- Breaks each granted transaction into START / ADDR / WRITE or READ / STOP byte commands; returns read data and status.
- Sits between on-chip clients and the bit-level SCL/SDA engine that drives the bus.

---
 rtl/i2c_txn_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// Round-robin scheduler that lets NUM_REQ clients share one byte-level I2C master
// engine, expanding each granted transaction into START/ADDR/DATA/STOP commands.
module i2c_txn_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]                 req_rw,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]       req_len,
  input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic                               wnext,
  output logic [I2C_DATA_WIDTH-1:0]          rdata,
  output logic                               rvalid,
  output logic                               done,
  output logic [1:0]                         err,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [2:0]                         cmd_op,
  output logic [I2C_DATA_WIDTH-1:0]          cmd_data,
  input  logic                               rsp_valid,
  input  logic                               rsp_nak,
  input  logic                               rsp_al,
  input  logic [I2C_DATA_WIDTH-1:0]          rsp_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [2:0] OP_START    = 3'd0;
  localparam logic [2:0] OP_STOP     = 3'd1;
  localparam logic [2:0] OP_WRITE    = 3'd2;
  localparam logic [2:0] OP_READ_ACK = 3'd3;
  localparam logic [2:0] OP_READ_NAK = 3'd4;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_ADDR_NAK = 2'd1;
  localparam logic [1:0] ERR_DATA_NAK = 2'd2;
  localparam logic [1:0] ERR_ARB_LOST = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_ISS, S_START_WAIT,
    S_ADDR_ISS,  S_ADDR_WAIT,
    S_DATA_ISS,  S_DATA_WAIT,
    S_STOP_ISS,  S_STOP_WAIT,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            ptr_q;
  logic [IDX_W-1:0]            owner_q;
  logic [IDX_W-1:0]            owner_inc;
  logic [NUM_REQ-1:0]          gnt_q;
  logic [1:0]                  err_q, err_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [I2C_ADDR_WIDTH-1:0]   addr_q;
  logic                        rw_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [I2C_DATA_WIDTH-1:0]   rdata_q;
  logic                        rvalid_q;
  logic                        grant_go;
  logic                        rd_take;
  logic                        win_found;
  logic [IDX_W-1:0]            win_idx;
  logic [IDX_W:0]              cand;
  logic [I2C_DATA_WIDTH-1:0]   addr_byte;
  logic [I2C_DATA_WIDTH-1:0]   owner_wdata;

  // Search starts at the round-robin pointer and wraps past NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign owner_inc   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
  assign addr_byte   = I2C_DATA_WIDTH'({addr_q, rw_q});
  assign owner_wdata = req_wdata[owner_q*I2C_DATA_WIDTH +: I2C_DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    grant_go  = 1'b0;
    rd_take   = 1'b0;
    wnext     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_START;
    cmd_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_go = 1'b1;
          err_d    = ERR_OK;
          state_d  = S_START_ISS;
        end
      end
      S_START_ISS: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
        if (cmd_ready) state_d = S_START_WAIT;
      end
      S_START_WAIT: begin
        if (rsp_al) begin
          err_d   = ERR_ARB_LOST;
          state_d = S_DONE;
        end else if (rsp_valid) begin
          state_d = S_ADDR_ISS;
        end
      end
      S_ADDR_ISS: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = addr_byte;
        if (cmd_ready) state_d = S_ADDR_WAIT;
      end
      S_ADDR_WAIT: begin
        if (rsp_al) begin
          err_d   = ERR_ARB_LOST;
          state_d = S_DONE;
        end else if (rsp_valid) begin
          if (rsp_nak) begin
            err_d   = ERR_ADDR_NAK;
            state_d = S_STOP_ISS;
          end else if (len_q == '0) begin
            state_d = S_STOP_ISS;
          end else begin
            cnt_d   = len_q;
            state_d = S_DATA_ISS;
          end
        end
      end
      S_DATA_ISS: begin
        cmd_valid = 1'b1;
        if (rw_q) begin
          cmd_op = (cnt_q > LEN_WIDTH'(1)) ? OP_READ_ACK : OP_READ_NAK;
        end else begin
          cmd_op   = OP_WRITE;
          cmd_data = owner_wdata;
        end
        if (cmd_ready) state_d = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        if (rsp_al) begin
          err_d   = ERR_ARB_LOST;
          state_d = S_DONE;
        end else if (rsp_valid) begin
          cnt_d = cnt_q - 1'b1;
          if (rw_q) begin
            rd_take = 1'b1;
            state_d = (cnt_q == LEN_WIDTH'(1)) ? S_STOP_ISS : S_DATA_ISS;
          end else begin
            wnext = 1'b1;
            if (rsp_nak) begin
              err_d   = ERR_DATA_NAK;
              state_d = S_STOP_ISS;
            end else begin
              state_d = (cnt_q == LEN_WIDTH'(1)) ? S_STOP_ISS : S_DATA_ISS;
            end
          end
        end
      end
      S_STOP_ISS: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        if (cmd_ready) state_d = S_STOP_WAIT;
      end
      S_STOP_WAIT: begin
        if (rsp_al) begin
          err_d   = ERR_ARB_LOST;
          state_d = S_DONE;
        end else if (rsp_valid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers; gnt drops on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      err_q    <= ERR_OK;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      rvalid_q <= rd_take;
      if (rd_take) rdata_q <= rsp_data;
      if (grant_go) begin
        owner_q <= win_idx;
        gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
      end else if (state_d == S_DONE) begin
        gnt_q <= '0;
      end
      if (state_q == S_DONE) ptr_q <= owner_inc;
    end
  end

  // Owner request fields are captured once at grant and ignored afterwards.
  always_ff @(posedge clk) begin
    if (grant_go) begin
      addr_q <= req_addr[win_idx*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
      rw_q   <= req_rw[win_idx];
      len_q  <= req_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
    end
    cnt_q <= cnt_d;
  end

  assign gnt    = gnt_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_DONE) ? err_q : ERR_OK;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: the initial block plays engine and requesters,
// a negedge monitor tallies wnext/rvalid/STOP pulses and grant overlap.
module tb_i2c_txn_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [3:0]  req_rw;
  logic [31:0] req_len;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic        wnext;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        done;
  logic [1:0]  err;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_nak;
  logic        rsp_al;
  logic [7:0]  rsp_data;

  i2c_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .wnext(wnext),
    .rdata(rdata), .rvalid(rvalid), .done(done), .err(err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nak(rsp_nak), .rsp_al(rsp_al), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int         wn_cnt     = 0;
  int         rv_cnt     = 0;
  int         stop_cnt   = 0;
  logic [7:0] last_rdata = '0;
  logic       gnt_multi  = 1'b0;
  logic [7:0] rlog[8];
  logic [7:0] wbytes[4];
  int         wbase = 0;

  // Each requester presents the current stream byte XOR a per-requester tag.
  always_comb begin
    req_wdata = '0;
    for (int r = 0; r < 4; r++)
      req_wdata[r*8 +: 8] = wbytes[2'(wn_cnt - wbase)] ^ 8'(r * 8'h11);
  end

  always @(negedge clk) begin
    if (wnext) wn_cnt <= wn_cnt + 1;
    if (rvalid) begin
      rv_cnt     <= rv_cnt + 1;
      last_rdata <= rdata;
      if (rv_cnt < 8) rlog[rv_cnt[2:0]] <= rdata;
    end
    if (cmd_valid && cmd_ready && cmd_op == 3'd1) stop_cnt <= stop_cnt + 1;
    if ($countones(gnt) > 1) gnt_multi <= 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [6:0] a, input logic rw, input logic [7:0] len);
    req_addr[r*7 +: 7] = a;
    req_rw[r]          = rw;
    req_len[r*8 +: 8]  = len;
  endtask

  task automatic wait_cmd(input logic [2:0] op, input logic [7:0] data, input bit use_data,
                          input string tag);
    int n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " cmd_valid"}, cmd_valid, 1);
    chk({tag, " cmd_op"}, cmd_op, op);
    if (use_data) chk({tag, " cmd_data"}, cmd_data, data);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic rsp(input bit nak, input bit al, input logic [7:0] d);
    rsp_valid = 1'b1;
    rsp_nak   = nak;
    rsp_al    = al;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
    rsp_nak   = 1'b0;
    rsp_al    = 1'b0;
    rsp_data  = '0;
  endtask

  task automatic wait_done(input logic [1:0] e, input string tag);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " err"}, err, e);
    chk({tag, " gnt clear at done"}, gnt, 0);
    tick();
  endtask

  task automatic wait_gnt(input logic [3:0] exp, input string tag);
    int n = 0;
    while (gnt == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " gnt"}, gnt, exp);
  endtask

  initial begin
    int exp_r[4];
    int wn0, rv0, st0;
    exp_r = '{0, 1, 3, 0};
    rst_n = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_len = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nak = 1'b0; rsp_al = 1'b0; rsp_data = '0;
    wbytes = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    tick(); tick();
    chk("reset gnt", gnt, 0);
    chk("reset cmd_valid", cmd_valid, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset rvalid", rvalid, 0);
    chk("reset rdata", rdata, 0);
    chk("reset wnext", wnext, 0);
    rst_n = 1'b1;
    tick();

    // Write from requester 0, two bytes
    set_req(0, 7'h22, 1'b0, 8'd2);
    wbase = wn_cnt; wn0 = wn_cnt;
    req = 4'b0001;
    tick();
    chk("wr gnt", gnt, 4'b0001);
    req = 4'b0000;
    wait_cmd(3'd0, 8'h00, 1'b0, "wr start");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h44, 1'b1, "wr addr");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'hA5, 1'b1, "wr byte0");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h3C, 1'b1, "wr byte1");
    rsp(0, 0, 0);
    wait_cmd(3'd1, 8'h00, 1'b0, "wr stop");
    rsp(0, 0, 0);
    wait_done(2'd0, "wr");
    chk("wr wnext count", wn_cnt - wn0, 2);

    // Read from requester 1, three bytes
    set_req(1, 7'h10, 1'b1, 8'd3);
    rv0 = rv_cnt;
    req = 4'b0010;
    wait_gnt(4'b0010, "rd");
    req = 4'b0000;
    wait_cmd(3'd0, 8'h00, 1'b0, "rd start");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h21, 1'b1, "rd addr");
    rsp(0, 0, 0);
    wait_cmd(3'd3, 8'h00, 1'b0, "rd ack0");
    rsp(0, 0, 8'h11);
    wait_cmd(3'd3, 8'h00, 1'b0, "rd ack1");
    rsp(0, 0, 8'h22);
    wait_cmd(3'd4, 8'h00, 1'b0, "rd nak2");
    rsp(0, 0, 8'h33);
    wait_cmd(3'd1, 8'h00, 1'b0, "rd stop");
    rsp(0, 0, 0);
    wait_done(2'd0, "rd");
    chk("rd rvalid count", rv_cnt - rv0, 3);
    chk("rd byte0", rlog[0], 8'h11);
    chk("rd byte1", rlog[1], 8'h22);
    chk("rd byte2", rlog[2], 8'h33);

    // Address NAK on requester 2
    set_req(2, 7'h22, 1'b0, 8'd2);
    wbase = wn_cnt; wn0 = wn_cnt;
    req = 4'b0100;
    wait_gnt(4'b0100, "anak");
    req = 4'b0000;
    wait_cmd(3'd0, 8'h00, 1'b0, "anak start");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h44, 1'b1, "anak addr");
    rsp(1, 0, 0);
    wait_cmd(3'd1, 8'h00, 1'b0, "anak stop");
    rsp(0, 0, 0);
    wait_done(2'd1, "anak");
    chk("anak wnext count", wn_cnt - wn0, 0);

    // Data NAK on first of three bytes, requester 3; stray rsp during issue is ignored
    set_req(3, 7'h05, 1'b0, 8'd3);
    wbytes = '{8'h5A, 8'h66, 8'h77, 8'h00};
    wbase = wn_cnt; wn0 = wn_cnt;
    req = 4'b1000;
    wait_gnt(4'b1000, "dnak");
    req = 4'b0000;
    rsp(0, 0, 0);
    wait_cmd(3'd0, 8'h00, 1'b0, "dnak start after stray rsp");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h0A, 1'b1, "dnak addr");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h69, 1'b1, "dnak byte0");
    rsp(1, 0, 0);
    wait_cmd(3'd1, 8'h00, 1'b0, "dnak stop");
    rsp(0, 0, 0);
    wait_done(2'd2, "dnak");
    chk("dnak wnext count", wn_cnt - wn0, 1);

    // Round-robin with req 1011 held: order 0,1,3,0
    for (int r = 0; r < 4; r++) set_req(r, 7'(8'h30 + r), 1'b0, 8'd0);
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(4'(1 << exp_r[k]), $sformatf("rr%0d", k));
      if (k == 3) req = 4'b0000;
      wait_cmd(3'd0, 8'h00, 1'b0, $sformatf("rr%0d start", k));
      rsp(0, 0, 0);
      wait_cmd(3'd2, 8'((8'h30 + exp_r[k]) << 1), 1'b1, $sformatf("rr%0d addr", k));
      rsp(0, 0, 0);
      wait_cmd(3'd1, 8'h00, 1'b0, $sformatf("rr%0d stop", k));
      rsp(0, 0, 0);
      wait_done(2'd0, $sformatf("rr%0d", k));
      chk($sformatf("rr%0d idle gap", k), gnt, 0);
    end

    // Arbitration lost during READ_ACK wait
    set_req(1, 7'h10, 1'b1, 8'd2);
    st0 = stop_cnt; rv0 = rv_cnt;
    req = 4'b0010;
    wait_gnt(4'b0010, "al");
    req = 4'b0000;
    wait_cmd(3'd0, 8'h00, 1'b0, "al start");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h21, 1'b1, "al addr");
    rsp(0, 0, 0);
    wait_cmd(3'd3, 8'h00, 1'b0, "al ack0");
    rsp(0, 1, 8'hEE);
    wait_done(2'd3, "al");
    chk("al stop count", stop_cnt - st0, 0);
    chk("al rvalid count", rv_cnt - rv0, 0);

    // Reset while issuing the first data byte; pointer returns to 0
    set_req(2, 7'h22, 1'b0, 8'd3);
    wbase = wn_cnt;
    req = 4'b0100;
    wait_gnt(4'b0100, "rst");
    wait_cmd(3'd0, 8'h00, 1'b0, "rst start");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h44, 1'b1, "rst addr");
    rsp(0, 0, 0);
    chk("rst data issue valid", cmd_valid, 1);
    chk("rst data issue byte", cmd_data, 8'h78);
    rst_n = 1'b0;
    #1;
    chk("rst async gnt", gnt, 0);
    chk("rst async cmd_valid", cmd_valid, 0);
    chk("rst async done", done, 0);
    tick();
    rst_n = 1'b1;
    set_req(0, 7'h22, 1'b0, 8'd0);
    req = 4'b0101;
    tick();
    chk("post-rst gnt", gnt, 4'b0001);
    req = 4'b0000;
    req_len[7:0] = 8'd5;
    wait_cmd(3'd0, 8'h00, 1'b0, "probe start");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'h44, 1'b1, "probe addr");
    rsp(0, 0, 0);
    wait_cmd(3'd1, 8'h00, 1'b0, "probe stop");
    rsp(0, 0, 0);
    wait_done(2'd0, "probe");

    // Maximum length read: 255 bytes
    set_req(3, 7'h7F, 1'b1, 8'd255);
    rv0 = rv_cnt;
    req = 4'b1000;
    wait_gnt(4'b1000, "max");
    req = 4'b0000;
    wait_cmd(3'd0, 8'h00, 1'b0, "max start");
    rsp(0, 0, 0);
    wait_cmd(3'd2, 8'hFF, 1'b1, "max addr");
    rsp(0, 0, 0);
    for (int k = 0; k < 255; k++) begin
      wait_cmd((k < 254) ? 3'd3 : 3'd4, 8'h00, 1'b0, $sformatf("max rd%0d", k));
      rsp(0, 0, 8'(k));
    end
    wait_cmd(3'd1, 8'h00, 1'b0, "max stop");
    rsp(0, 0, 0);
    wait_done(2'd0, "max");
    chk("max rvalid count", rv_cnt - rv0, 255);
    chk("max last rdata", last_rdata, 8'hFE);

    chk("gnt never overlapped", gnt_multi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
